// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package if_fetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Small synchronous FIFO with flush; used for the {PC,IR} queue and the pc_tag queue.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    count     = count_q;
    head_data = mem_q[rd_q];
    pop_ok    = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle
    push_ok   = push && (!full || pop_ok);
    mem_d     = mem_q;
    wr_d      = wr_q + AW'(push_ok);
    rd_d      = rd_q + AW'(pop_ok);
    count_d   = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) mem_d[wr_q] = push_data;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch PC owner: issues in-order imem reads under a credit limit and queues {PC,IR} for ID.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        fetch_valid,
  output logic [31:0] PC,
  output logic [31:0] IR,
  output logic        fetch_err
);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   fpc_q, fpc_d, hold_pc_q, hold_pc_d, hold_ir_q, hold_ir_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d;
  logic          err_q, err_d;
  logic [CW:0]   inflight;
  logic          req_fire, resp_take, pop;

  logic [63:0]   q_head;
  logic [CW-1:0] q_count;
  logic          q_empty, q_full_unused;
  logic [31:0]   tag_head;
  logic [CW-1:0] tag_count_unused;
  logic          tag_empty_unused, tag_full_unused;

  always_comb begin
    inflight       = {1'b0, out_q} + {1'b0, q_count};
    imem_req_valid = !reset && !redirect && !err_q && !misaligned(fpc_q[1:0])
                     && (inflight < (CW+1)'(DEPTH));
    imem_req_addr  = fpc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // Anything returning during a redirect or while stale reads are pending belongs to the old path
    resp_take      = imem_resp_valid && !redirect && (drop_q == '0);
    fetch_valid    = !q_empty;
    fetch_err      = err_q;
    pop            = fetch_valid && !stall && !redirect;
    PC             = q_empty ? hold_pc_q : q_head[63:32];
    IR             = q_empty ? hold_ir_q : q_head[31:0];
    hold_pc_d      = PC;
    hold_ir_d      = IR;

    fpc_d  = fpc_q;
    out_d  = out_q;
    drop_d = drop_q;
    err_d  = err_q | misaligned(fpc_q[1:0]);
    if (redirect) begin
      fpc_d  = redirect_pc;
      out_d  = '0;
      err_d  = 1'b0;
      drop_d = (drop_q != '0 || out_q != '0) ? drop_q + out_q - CW'(imem_resp_valid) : '0;
    end else begin
      if (req_fire) fpc_d = fpc_q + 32'd4;
      out_d = out_q + CW'(req_fire) - CW'(resp_take);
      if (imem_resp_valid && drop_q != '0) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q     <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      err_q     <= 1'b0;
      hold_pc_q <= '0;
      hold_ir_q <= NOP_WORD;
    end else begin
      fpc_q     <= fpc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
      hold_pc_q <= hold_pc_d;
      hold_ir_q <= hold_ir_d;
    end
  end

  fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_queue (
    .clk(clk), .reset(reset), .flush(redirect),
    .push(resp_take), .push_data({tag_head, imem_resp_data}), .pop(pop),
    .head_data(q_head), .count(q_count), .empty(q_empty), .full(q_full_unused)
  );

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_tag (
    .clk(clk), .reset(reset), .flush(redirect),
    .push(req_fire), .push_data(fpc_q), .pop(resp_take),
    .head_data(tag_head), .count(tag_count_unused), .empty(tag_empty_unused),
    .full(tag_full_unused)
  );

endmodule
